// File: rtl/aq_axi_sdma64_intret.sv
// -----------------------------------------------------------------------------
// aq_axi_sdma64_intret
//
// Moves DW-bit status words from the CLKB (source) domain to the CLKA
// (destination) domain using a 4-phase req/ack handshake. Each delivered word
// is held on DST_DATA with DST_VALID high until the consumer takes it. Each new
// delivery raises DST_IRQ for one CLKA cycle.
//
// Data path: the source latches the word into a hold register and raises req.
// req crosses into CLKA through a 2-flop synchronizer. The destination copies
// the hold register once the synchronized req is seen. By then the hold register
// has been stable for at least two CLKA edges, so the multi-bit value is never
// sampled while it changes. ack returns to CLKB through its own 2-flop
// synchronizer.
//
// Ports
//   RST_N      in   1   shared async active-low reset (release pre-synchronized
//                       per domain outside this block)
//   CLKA       in   1   destination clock
//   CLKB       in   1   source clock, asynchronous to CLKA
//   SRC_VALID  in   1   source word available                     (CLKB)
//   SRC_DATA   in   DW  source word                               (CLKB)
//   SRC_READY  out  1   block can take a word                     (CLKB)
//   DST_VALID  out  1   word held for the consumer                (CLKA)
//   DST_DATA   out  DW  delivered word                            (CLKA)
//   DST_READY  in   1   consumer accepts the held word            (CLKA)
//   DST_IRQ    out  1   one-cycle pulse per new delivery          (CLKA)
// -----------------------------------------------------------------------------
module aq_axi_sdma64_intret #(
    parameter int DW = 32
) (
    input  logic          RST_N,
    input  logic          CLKA,
    input  logic          CLKB,
    input  logic          SRC_VALID,
    input  logic [DW-1:0] SRC_DATA,
    output logic          SRC_READY,
    output logic          DST_VALID,
    output logic [DW-1:0] DST_DATA,
    input  logic          DST_READY,
    output logic          DST_IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } src_state_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_HOLD = 2'd1,
        D_ACK  = 2'd2
    } dst_state_t;

    // ---------------------------------------------------------------- CLKB side
    src_state_t    src_state;
    logic          src_req;
    logic [DW-1:0] src_hold;
    logic [1:0]    ack_meta;
    logic          ack_sync;

    // ---------------------------------------------------------------- CLKA side
    dst_state_t    dst_state;
    logic          dst_ack;
    logic [1:0]    req_meta;
    logic          req_sync;

    assign ack_sync = ack_meta[1];
    assign req_sync = req_meta[1];

    // ack -> CLKB synchronizer. Only the single-bit ack crosses here.
    // NOTE: sequential state is always written with non-blocking (<=) assignments,
    // so every flop samples the values from before the edge. This makes the
    // two-stage shift behave as a real synchronizer.
    always_ff @(posedge CLKB or negedge RST_N) begin
        if (!RST_N) begin
            ack_meta <= 2'b00;
        end else begin
            ack_meta <= {ack_meta[0], dst_ack};
        end
    end

    // Source FSM. SRC_READY is registered and tracks entry into and exit from
    // S_IDLE. It is 1 during reset and 1 while S_IDLE is active, so a SRC_VALID
    // present when S_IDLE is re-entered is taken on the following CLKB edge.
    // SRC_VALID seen while SRC_READY is 0 has no effect; the source simply retries.
    // NOTE: the hold register is a plain data register, not a memory array. It is
    // reset anyway, because it leaves the block through the synchronized capture
    // path, and a known value after reset keeps DST_DATA deterministic.
    always_ff @(posedge CLKB or negedge RST_N) begin
        if (!RST_N) begin
            src_state <= S_IDLE;
            src_req   <= 1'b0;
            src_hold  <= '0;
            SRC_READY <= 1'b1;
        end else begin
            case (src_state)
                S_IDLE: begin
                    if (SRC_VALID) begin
                        src_hold  <= SRC_DATA;
                        src_req   <= 1'b1;
                        SRC_READY <= 1'b0;
                        src_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // src_hold is frozen until the destination has taken it.
                    if (ack_sync) begin
                        src_req   <= 1'b0;
                        src_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Wait for ack to drop, which closes the 4-phase loop.
                    if (!ack_sync) begin
                        SRC_READY <= 1'b1;
                        src_state <= S_IDLE;
                    end
                end
                default: begin
                    src_req   <= 1'b0;
                    SRC_READY <= 1'b1;
                    src_state <= S_IDLE;
                end
            endcase
        end
    end

    // req -> CLKA synchronizer. src_hold is deliberately not routed through any
    // synchronizer flop. It is sampled directly, and only after req_sync
    // guarantees that it is quiet.
    always_ff @(posedge CLKA or negedge RST_N) begin
        if (!RST_N) begin
            req_meta <= 2'b00;
        end else begin
            req_meta <= {req_meta[0], src_req};
        end
    end

    // Destination FSM. DST_IRQ defaults low each cycle, so any pulse raised on
    // capture lasts exactly one CLKA cycle. DST_READY is looked at only in
    // D_HOLD.
    always_ff @(posedge CLKA or negedge RST_N) begin
        if (!RST_N) begin
            dst_state <= D_IDLE;
            dst_ack   <= 1'b0;
            DST_VALID <= 1'b0;
            DST_DATA  <= '0;
            DST_IRQ   <= 1'b0;
        end else begin
            DST_IRQ <= 1'b0;
            case (dst_state)
                D_IDLE: begin
                    if (req_sync) begin
                        DST_DATA  <= src_hold;
                        DST_VALID <= 1'b1;
                        DST_IRQ   <= 1'b1;
                        dst_state <= D_HOLD;
                    end
                end
                D_HOLD: begin
                    if (DST_READY) begin
                        DST_VALID <= 1'b0;
                        dst_ack   <= 1'b1;
                        dst_state <= D_ACK;
                    end
                end
                D_ACK: begin
                    // Hold ack until the source has dropped req. This prevents the
                    // same word from being captured twice.
                    if (!req_sync) begin
                        dst_ack   <= 1'b0;
                        dst_state <= D_IDLE;
                    end
                end
                default: begin
                    dst_ack   <= 1'b0;
                    DST_VALID <= 1'b0;
                    dst_state <= D_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aq_axi_sdma64_intret.sv
// -----------------------------------------------------------------------------
// tb_aq_axi_sdma64_intret
//
// Bench for aq_axi_sdma64_intret with two independently timed clocks.
//
// Source driver (runs on CLKB negedges):
//   - offers words from an incrementing counter;
//   - pushes each word into a queue of expected values at the moment the word
//     will be taken on the next CLKB edge.
//
// Monitor (runs on CLKA negedges):
//   - pops one expected value per DST_IRQ pulse and compares it with DST_DATA.
//
// Directed phases:
//   - single word;
//   - streaming;
//   - consumer stall;
//   - reset mid-transfer;
//   - random clock ratios with jitter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aq_axi_sdma64_intret;

    localparam int DW = 32;

    logic          RST_N;
    logic          CLKA;
    logic          CLKB;
    logic          SRC_VALID;
    logic [DW-1:0] SRC_DATA;
    logic          SRC_READY;
    logic          DST_VALID;
    logic [DW-1:0] DST_DATA;
    logic          DST_READY;
    logic          DST_IRQ;

    aq_axi_sdma64_intret #(.DW(DW)) dut (
        .RST_N     (RST_N),
        .CLKA      (CLKA),
        .CLKB      (CLKB),
        .SRC_VALID (SRC_VALID),
        .SRC_DATA  (SRC_DATA),
        .SRC_READY (SRC_READY),
        .DST_VALID (DST_VALID),
        .DST_DATA  (DST_DATA),
        .DST_READY (DST_READY),
        .DST_IRQ   (DST_IRQ)
    );

    // Clock control. Half periods are in ns; jitter adds up to 0.3 ns per half.
    real half_a = 5.0;
    real half_b = 15.15;
    bit  jit_on = 1'b0;

    initial begin
        CLKA = 1'b0;
        forever begin
            #(half_a + (jit_on ? $urandom_range(0, 300) / 1000.0 : 0.0));
            CLKA = ~CLKA;
        end
    end

    initial begin
        CLKB = 1'b0;
        forever begin
            #(half_b + (jit_on ? $urandom_range(0, 300) / 1000.0 : 0.0));
            CLKB = ~CLKB;
        end
    end

    // Shared bench state.
    logic [DW-1:0] exp_q[$];
    int            n_tests   = 0;
    int            n_fail    = 0;
    int            irq_count = 0;
    int            send_left = 0;
    int            src_pct   = 100;
    int            dst_pct   = 100;
    bit            src_acc   = 1'b0;
    logic [DW-1:0] word_ctr  = '0;
    bit            prev_irq  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Source driver. Inputs change only on CLKB negedges. SRC_READY seen here
    // is therefore the value the DUT uses at the next posedge.
    initial begin
        SRC_VALID = 1'b0;
        SRC_DATA  = '0;
        forever begin
            @(negedge CLKB);
            if (src_acc) begin
                src_acc = 1'b0;
                send_left--;
                word_ctr++;
            end
            if (RST_N && send_left > 0 && $urandom_range(0, 99) < src_pct) begin
                SRC_VALID = 1'b1;
                SRC_DATA  = word_ctr;
            end else begin
                SRC_VALID = 1'b0;
            end
            if (SRC_VALID && SRC_READY) begin
                exp_q.push_back(SRC_DATA);
                src_acc = 1'b1;
            end
        end
    end

    // Consumer driver.
    initial begin
        DST_READY = 1'b0;
        forever begin
            @(negedge CLKA);
            DST_READY = ($urandom_range(0, 99) < dst_pct);
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge CLKA);
            if (RST_N && DST_IRQ) begin
                irq_count++;
                check("irq_single_cycle", {63'd0, prev_irq}, 64'd0);
                check("valid_with_irq", {63'd0, DST_VALID}, 64'd1);
                check("word_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    check("data", DST_DATA, exp_q.pop_front());
                end
            end
            prev_irq = DST_IRQ;
        end
    end

    // Wait until all offered words have been delivered and the handshake has
    // closed.
    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((send_left != 0 || src_acc || exp_q.size() != 0 || !SRC_READY) && n < budget) begin
            @(negedge CLKA);
            n++;
        end
        check({tag, "_timeout"}, {63'd0, n >= budget}, 64'd0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!DST_VALID && n < budget) begin
            @(negedge CLKA);
            n++;
        end
        check({tag, "_timeout"}, {63'd0, n >= budget}, 64'd0);
    endtask

    task automatic send(input logic [DW-1:0] first, input int count);
        word_ctr  = first;
        send_left = count;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1);
    end

    initial begin
        int base;
        int width;

        // ---------------------------------------------------------- reset state
        RST_N = 1'b0;
        repeat (4) @(negedge CLKB);
        check("rst_src_ready", {63'd0, SRC_READY}, 64'd1);
        check("rst_dst_valid", {63'd0, DST_VALID}, 64'd0);
        check("rst_dst_irq", {63'd0, DST_IRQ}, 64'd0);
        check("rst_dst_data", DST_DATA, 64'd0);
        @(negedge CLKA);
        RST_N = 1'b1;
        repeat (5) @(negedge CLKA);

        // ---------------------------------------------------------- single word, 100/33 MHz
        dst_pct = 100;
        base    = irq_count;
        send(32'h0000_00A5, 1);
        wait_valid("p1_valid", 500);
        width = 0;
        while (DST_VALID && width < 10) begin
            width++;
            @(negedge CLKA);
        end
        check("p1_valid_width", width, 1);
        wait_idle("p1", 2000);
        check("p1_irq_count", irq_count - base, 1);
        check("p1_dst_data", DST_DATA, 32'h0000_00A5);

        // ---------------------------------------------------------- streaming, 25/200 MHz
        half_a  = 20.0;
        half_b  = 2.5;
        src_pct = 100;
        base    = irq_count;
        send(32'd0, 300);
        wait_idle("p2", 300 * 100 + 1000);
        check("p2_irq_count", irq_count - base, 300);

        // ---------------------------------------------------------- consumer stall
        half_a  = 5.0;
        half_b  = 15.15;
        dst_pct = 0;
        repeat (4) @(negedge CLKA);
        base = irq_count;
        send(32'h0000_0100, 2);
        wait_valid("p3_valid", 500);
        @(negedge CLKA);
        for (int i = 0; i < 50; i++) begin
            check("p3_hold_valid", {63'd0, DST_VALID}, 64'd1);
            check("p3_hold_data", DST_DATA, 32'h0000_0100);
            check("p3_src_ready", {63'd0, SRC_READY}, 64'd0);
            check("p3_no_new_irq", irq_count - base, 1);
            @(negedge CLKA);
        end
        dst_pct = 100;
        wait_idle("p3", 3000);
        check("p3_irq_count", irq_count - base, 2);
        check("p3_last_data", DST_DATA, 32'h0000_0101);

        // ---------------------------------------------------------- reset mid-transfer
        dst_pct = 0;
        repeat (4) @(negedge CLKA);
        send(32'h0000_0055, 1);
        wait_valid("p4_valid", 500);
        repeat (3) @(negedge CLKA);
        #1;
        RST_N = 1'b0;
        exp_q.delete();
        send_left = 0;
        #1;
        check("p4_rst_src_ready", {63'd0, SRC_READY}, 64'd1);
        check("p4_rst_dst_valid", {63'd0, DST_VALID}, 64'd0);
        check("p4_rst_dst_irq", {63'd0, DST_IRQ}, 64'd0);
        check("p4_rst_dst_data", DST_DATA, 64'd0);
        repeat (3) @(negedge CLKB);
        @(negedge CLKA);
        RST_N   = 1'b1;
        dst_pct = 100;
        base    = irq_count;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLKA);
            check("p4_no_spurious_valid", {63'd0, DST_VALID}, 64'd0);
        end
        check("p4_no_spurious_irq", irq_count - base, 0);
        send(32'h0000_1234, 1);
        wait_idle("p4", 3000);
        check("p4_irq_count", irq_count - base, 1);
        check("p4_dst_data", DST_DATA, 32'h0000_1234);

        // ---------------------------------------------------------- random ratios with jitter
        jit_on = 1'b1;
        for (int seg = 0; seg < 4; seg++) begin
            half_a  = $urandom_range(2000, 14000) / 1000.0;
            half_b  = $urandom_range(2000, 14000) / 1000.0;
            src_pct = $urandom_range(30, 100);
            dst_pct = $urandom_range(30, 100);
            base    = irq_count;
            send(32'h0001_0000 * (seg + 1), 200);
            wait_idle("p5", 200 * 600 + 1000);
            check("p5_irq_count", irq_count - base, 200);
        end

        repeat (4) @(negedge CLKA);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
